// File: rtl/clkdiv_bank.sv
// Bank of independent programmable clock dividers with shadowed configuration.
// A new divisor/mode is applied only at a wrap, a sync, or while the channel is disabled.
module clkdiv_bank #(
  parameter  int WIDTH        = 16,
  parameter  int CHANNELS     = 4,
  parameter  int DEFAULT_DIV  = 1,
  parameter  int DEFAULT_MODE = 0,
  localparam int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] clkout,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [WIDTH-1:0]    r_cnt   [CHANNELS];
  logic [WIDTH-1:0]    r_div_a [CHANNELS];
  logic [WIDTH-1:0]    r_div_s [CHANNELS];
  logic [CHANNELS-1:0] r_mode_a;
  logic [CHANNELS-1:0] r_mode_s;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_clkout;
  logic [CHANNELS-1:0] r_tick;

  logic                w_cfg_ok;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_wrap;
  logic [CHANNELS-1:0] w_apply;
  logic [CHANNELS-1:0] w_mode_chg;

  // The apply decision reads the shadow before any coincident write lands in it.
  always_comb begin
    w_cfg_ok   = cfg_we && (32'(cfg_ch) < CHANNELS);
    w_wr       = '0;
    w_wrap     = '0;
    w_apply    = '0;
    w_mode_chg = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr[i]       = w_cfg_ok && (32'(cfg_ch) == i);
      w_wrap[i]     = en[i] && (r_cnt[i] == r_div_a[i]);
      w_apply[i]    = r_pending[i] && (sync || !en[i] || w_wrap[i]);
      w_mode_chg[i] = w_apply[i] && (r_mode_s[i] != r_mode_a[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]   <= '0;
        r_div_a[i] <= WIDTH'(DEFAULT_DIV);
        r_div_s[i] <= WIDTH'(DEFAULT_DIV);
      end
      r_mode_a  <= {CHANNELS{1'(DEFAULT_MODE)}};
      r_mode_s  <= {CHANNELS{1'(DEFAULT_MODE)}};
      r_pending <= '0;
      r_clkout  <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_apply[i]) begin
          r_div_a[i]  <= r_div_s[i];
          r_mode_a[i] <= r_mode_s[i];
        end

        if (w_wr[i]) begin
          r_div_s[i]   <= cfg_div;
          r_mode_s[i]  <= cfg_mode;
          r_pending[i] <= 1'b1;
        end else if (w_apply[i]) begin
          r_pending[i] <= 1'b0;
        end

        if (sync || !en[i]) begin
          r_cnt[i]    <= '0;
          r_clkout[i] <= 1'b0;
          r_tick[i]   <= 1'b0;
        end else if (w_wrap[i]) begin
          r_cnt[i] <= '0;
          if (w_mode_chg[i]) begin
            r_clkout[i] <= 1'b0;
            r_tick[i]   <= 1'b0;
          end else if (r_mode_a[i]) begin
            r_clkout[i] <= 1'b0;
            r_tick[i]   <= 1'b1;
          end else begin
            r_clkout[i] <= ~r_clkout[i];
            r_tick[i]   <= 1'b0;
          end
        end else begin
          r_cnt[i]  <= r_cnt[i] + WIDTH'(1);
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign clkout  = r_clkout;
  assign tick    = r_tick;
  assign pending = r_pending;

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank: a 3-channel bank plus a 1-channel 3-bit bank
// running at the maximum divisor in pulse mode.
module tb_clkdiv_bank;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic        sync;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [2:0]  clkout;
  logic [2:0]  tick;
  logic [2:0]  pending;

  logic [0:0]  clkout_w3;
  logic [0:0]  tick_w3;
  logic [0:0]  pending_w3;

  int n_checks = 0;
  int n_fail   = 0;

  clkdiv_bank #(.WIDTH(16), .CHANNELS(3), .DEFAULT_DIV(1), .DEFAULT_MODE(0)) u_dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .clkout(clkout), .tick(tick), .pending(pending)
  );

  clkdiv_bank #(.WIDTH(3), .CHANNELS(1), .DEFAULT_DIV(7), .DEFAULT_MODE(1)) u_dut_w3 (
    .clk(clk), .reset(reset), .en(1'b1), .sync(1'b0),
    .cfg_we(1'b0), .cfg_ch(1'b0), .cfg_div(3'd0), .cfg_mode(1'b0),
    .clkout(clkout_w3), .tick(tick_w3), .pending(pending_w3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [15:0] dv, input logic md);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_mode = md;
  endtask

  // 16 edges with defaults: toggle D=1 gives 0110 repeating; the 3-bit bank ticks every 8th edge.
  task automatic run_default_check(input string tag);
    logic [15:0] p0, p1, p2, pw;
    logic [2:0]  tick_or;
    logic        w3_clk_or;
    p0 = '0; p1 = '0; p2 = '0; pw = '0; tick_or = '0; w3_clk_or = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      p0 = {p0[14:0], clkout[0]};
      p1 = {p1[14:0], clkout[1]};
      p2 = {p2[14:0], clkout[2]};
      pw = {pw[14:0], tick_w3[0]};
      tick_or   = tick_or | tick;
      w3_clk_or = w3_clk_or | clkout_w3[0];
    end
    check_val({tag, "_clk0"}, 32'(p0), 32'h6666);
    check_val({tag, "_clk1"}, 32'(p1), 32'h6666);
    check_val({tag, "_clk2"}, 32'(p2), 32'h6666);
    check_val({tag, "_tick"}, 32'(tick_or), 32'h0);
    check_val({tag, "_w3tick"}, 32'(pw), 32'h0101);
    check_val({tag, "_w3clk"}, 32'(w3_clk_or), 32'h0);
  endtask

  initial begin
    logic [8:0]  pt1;
    logic [9:0]  pc2;
    logic [5:0]  s0, s1, s2;
    logic        c1_or;

    reset = 1'b1; en = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    #2;
    check_val("rst_clkout", 32'(clkout), 32'h0);
    check_val("rst_tick", 32'(tick), 32'h0);
    check_val("rst_pending", 32'(pending), 32'h0);
    step();
    step();
    en = 3'b111;
    reset = 1'b0;

    run_default_check("dflt");

    // ch1 -> D=2 pulse, written mid-count
    write_cfg(2'd1, 16'd2, 1'b1);
    step();
    cfg_we = 1'b0;
    check_val("ch1_pend_set", 32'(pending), 32'h2);
    step();
    check_val("ch1_pend_clr", 32'(pending), 32'h0);
    check_val("ch1_apply_tick", 32'(tick[1]), 32'h0);
    check_val("ch1_apply_clk", 32'(clkout[1]), 32'h0);
    pt1 = '0; c1_or = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      pt1 = {pt1[7:0], tick[1]};
      c1_or = c1_or | clkout[1];
    end
    check_val("ch1_tick_pat", 32'(pt1), 32'h049);
    check_val("ch1_clk_low", 32'(c1_or), 32'h0);

    // ch2 -> D=4 written exactly on its wrap edge
    write_cfg(2'd2, 16'd4, 1'b0);
    step();
    cfg_we = 1'b0;
    check_val("ch2_pend_wr", 32'(pending), 32'h4);
    check_val("ch2_clk_wr", 32'(clkout[2]), 32'h0);
    step();
    check_val("ch2_pend_hold", 32'(pending), 32'h4);
    step();
    check_val("ch2_pend_clr", 32'(pending), 32'h0);
    check_val("ch2_clk_apply", 32'(clkout[2]), 32'h1);
    pc2 = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      pc2 = {pc2[8:0], clkout[2]};
    end
    check_val("ch2_period10", 32'(pc2), 32'h3C1);

    // D = 1/3/5 then sync
    write_cfg(2'd1, 16'd3, 1'b0);
    step();
    write_cfg(2'd2, 16'd5, 1'b0);
    step();
    cfg_we = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_val("sync_clk", 32'(clkout), 32'h0);
    check_val("sync_tick", 32'(tick), 32'h0);
    check_val("sync_pend", 32'(pending), 32'h0);
    s0 = '0; s1 = '0; s2 = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      s0 = {s0[4:0], clkout[0]};
      s1 = {s1[4:0], clkout[1]};
      s2 = {s2[4:0], clkout[2]};
    end
    check_val("sync_ch0", 32'(s0), 32'h19);
    check_val("sync_ch1", 32'(s1), 32'h07);
    check_val("sync_ch2", 32'(s2), 32'h01);

    // out-of-range channel write is ignored
    write_cfg(2'd3, 16'd7, 1'b1);
    step();
    cfg_we = 1'b0;
    check_val("bad_ch_pend", 32'(pending), 32'h0);

    // ch0 disabled for 5 edges; a write while disabled is applied on the next edge
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) write_cfg(2'd0, 16'd1, 1'b0);
      step();
      cfg_we = 1'b0;
      check_val("dis_clk0", 32'(clkout[0]), 32'h0);
      if (k == 1) check_val("dis_pend_set", 32'(pending), 32'h1);
      if (k == 2) check_val("dis_pend_clr", 32'(pending), 32'h0);
    end
    en[0] = 1'b1;
    step();
    check_val("restart_e1", 32'(clkout[0]), 32'h0);
    step();
    check_val("restart_e2", 32'(clkout[0]), 32'h1);

    // asynchronous reset between edges while a write is pending
    write_cfg(2'd1, 16'd9, 1'b1);
    step();
    cfg_we = 1'b0;
    check_val("pre_rst_pend", 32'(pending), 32'h2);
    check_val("pre_rst_clk0", 32'(clkout[0]), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_clk", 32'(clkout), 32'h0);
    check_val("arst_tick", 32'(tick), 32'h0);
    check_val("arst_pend", 32'(pending), 32'h0);
    step();
    step();
    reset = 1'b0;
    run_default_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_bank.md
CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 Parameter WIDTH, default 16, bit width of divisors and counters.
REQ-002 Parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-003 Parameter DEFAULT_DIV, default 1, divisor value loaded into every channel at reset.
REQ-004 Parameter DEFAULT_MODE, default 0, mode loaded at reset (0 = toggle, 1 = pulse).
REQ-005 Localparam CHW = max(1, ceil(log2(CHANNELS))), width of the channel select.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- sync  in  1  one-cycle strobe that restarts all channels together.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CHW  target channel of the write.
- cfg_div  in  WIDTH  new divisor D.
- cfg_mode  in  1  new mode.
- clkout  out  CHANNELS  divided clock (toggle mode).
- tick  out  CHANNELS  one-cycle enable strobe (pulse mode).
- pending  out  CHANNELS  a written configuration is waiting to be applied.

Function
REQ-007 Per channel, the block SHALL hold: a counter cnt, an active divisor/mode (div_a, mode_a), a shadow divisor/mode (div_s, mode_s), and a pending flag. All outputs are registered.
REQ-008 Wrap: when en=1 and cnt==div_a at a clk edge, cnt SHALL load 0; otherwise, when en=1, cnt SHALL load cnt+1.
REQ-009 Toggle mode: clkout SHALL invert at each wrap edge; tick SHALL stay 0. Output period = 2*(D+1) cycles with 50% duty; D=0 gives divide-by-2.
REQ-010 Pulse mode: tick SHALL be 1 for exactly the cycle after each wrap edge, 0 otherwise; clkout SHALL stay 0. Period = D+1; D=0 gives tick constantly 1.
REQ-011 cfg_we=1 with cfg_ch < CHANNELS SHALL load div_s/mode_s of that channel and set its pending flag on the same edge. A write with cfg_ch >= CHANNELS SHALL be ignored.
REQ-012 A write to a channel that is already pending SHALL overwrite the shadow; pending stays 1.
REQ-013 Glitch-free update: at a wrap edge with pending=1, div_a/mode_a SHALL load the shadow and pending SHALL clear. The new divisor governs the next count sequence.
REQ-014 If a write to a channel coincides with that channel's wrap edge, the wrap SHALL apply the pre-write shadow (if pending). The written value SHALL be stored in the shadow with pending=1.
REQ-015 On a mode change at apply, clkout and tick SHALL be forced to 0 on that edge.
REQ-016 en=0: cnt SHALL hold 0; clkout and tick SHALL be 0 from the next edge. A pending shadow SHALL be applied on that next edge (pending cleared). Re-assertion of en SHALL start counting from 0, so the first wrap occurs D+1 edges later.
REQ-017 sync=1: every channel SHALL set cnt=0 and clkout=0, and tick=0 on that edge; pending shadows SHALL be applied. sync has priority over wrap; a coincident write follows REQ-014 (it lands in the shadow, pending=1).
REQ-018 Arithmetic SHALL be unsigned WIDTH bits. cnt never exceeds div_a, so it never wraps modulo 2^WIDTH. D = 2^WIDTH-1 SHALL be supported.
REQ-019 Channels SHALL be fully independent except for the shared sync and configuration port.

Reset
REQ-020 While reset=1, regardless of clk: cnt=0, clkout=0, tick=0, pending=0, div_a=div_s=DEFAULT_DIV, mode_a=mode_s=DEFAULT_MODE.
REQ-021 Reset asserted mid-count or mid-pending SHALL discard all shadows. The first wrap after release SHALL occur DEFAULT_DIV+1 enabled edges later.

Verification
REQ-022 Reset, en=all 1, defaults (D=1, toggle) -> every clkout has period 4 cycles, high 2; tick stays 0.
REQ-023 Write ch1 D=2, mode=1 mid-count -> pending[1]=1 until the next ch1 wrap; then tick[1] is high 1 cycle in every 3, with clkout[1]=0 and no runt pulse.
REQ-024 Write ch2 D=4 exactly on its wrap edge -> old D=1 sequence completes once more, then D=4 applies (toggle period 10); pending[2] clears at that wrap.
REQ-025 Channels at D=1/3/5, sync pulse -> all counters zero and clkouts 0 on the same edge; rising edges realign to 2/4/6 cycles after sync.
REQ-026 CHANNELS=3, write cfg_ch=3 -> no state change, pending=000. Then en[0]=0 for 5 cycles -> clkout[0]=0; restart gives its first toggle 2 edges after en rises.
REQ-027 Assert reset asynchronously between clk edges during pending writes -> outputs 0 immediately; after release, the defaults of REQ-022 are restored.
